l1_cdreq_seq: RTL and testbench

- Sequential controller for one L1 cache's CPU-down request (cdreq) path.
- Accepts one CPU request at a time and samples the tag-lookup result to classify it as read/write hit/miss.
- Issues the downstream snoop request (sdreq) when coherence requires it, waits for the upstream snoop response (sursp), commits the block state, then returns the CPU-up response (cursp).
- Drives req_curSt/req_status, which the L1 next-state/sdreq decoder consumes; takes that decoder's sdreq opcode back as an input.

---
 rtl/l1_cdreq_seq_pkg.sv | 51 +++++
 rtl/l1_cdreq_seq_if.sv | 64 ++++++
 rtl/l1_sursp_timer.sv | 32 +++
 rtl/l1_cdreq_seq.sv | 130 +++++++++++++
 tb/tb_l1_cdreq_seq.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_cdreq_seq_pkg.sv
// Shared encodings for the L1 CPU-down request sequencer.
// Sequencer states, MESI codes, sdreq/sursp/cursp opcodes.
package l1_cdreq_seq_pkg;

    typedef logic [2:0] cdreq_st_e;

    localparam cdreq_st_e CDREQ_IDLE       = 3'd0;
    localparam cdreq_st_e CDREQ_LOOKUP     = 3'd1;
    localparam cdreq_st_e CDREQ_SEND_SDREQ = 3'd2;
    localparam cdreq_st_e CDREQ_WAIT_SURSP = 3'd3;
    localparam cdreq_st_e CDREQ_UPDATE     = 3'd4;
    localparam cdreq_st_e CDREQ_SEND_RSP   = 3'd5;

    localparam logic [2:0] MESI_I = 3'd0;
    localparam logic [2:0] MESI_S = 3'd1;
    localparam logic [2:0] MESI_E = 3'd2;
    localparam logic [2:0] MESI_M = 3'd3;

    localparam int READ_HIT   = 0;
    localparam int WRITE_HIT  = 1;
    localparam int READ_MISS  = 2;
    localparam int WRITE_MISS = 3;

    localparam logic [2:0] SDREQ_RD  = 3'd0;
    localparam logic [2:0] SDREQ_RDX = 3'd1;
    localparam logic [2:0] SDREQ_INV = 3'd2;
    localparam logic [2:0] SDREQ_WB  = 3'd3;

    localparam logic [2:0] SURSP_NULL  = 3'd0;
    localparam logic [2:0] SURSP_SNOOP = 3'd1;
    localparam logic [2:0] SURSP_FETCH = 3'd2;

    localparam logic [1:0] CURSP_OKAY = 2'b00;
    localparam logic [1:0] CURSP_ERR  = 2'b10;

    function automatic logic [3:0] req_class(
        input logic hit,
        input logic wr
    );
        logic [3:0] s;
        s = 4'b0000;
        unique case (1'b1)
            (hit && !wr):  s[READ_HIT]   = 1'b1;
            (hit && wr):   s[WRITE_HIT]  = 1'b1;
            (!hit && !wr): s[READ_MISS]  = 1'b1;
            default:       s[WRITE_MISS] = 1'b1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/l1_cdreq_seq_if.sv
// Bundle of the cdreq sequencer's CPU, lookup, snoop and decoder signals.
// master = sequencer side, slave = surrounding cache logic.
interface l1_cdreq_seq_if
    import l1_cdreq_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
);

    logic                  cdreq_valid;
    logic                  cdreq_ready;
    logic                  cdreq_wr;
    logic [ADDR_WIDTH-1:0] cdreq_addr;

    logic                  lkup_hit;
    logic                  lkup_en;
    logic [ADDR_WIDTH-1:0] lkup_addr;
    logic [2:0]            blk_curSt;
    logic                  snp_busy;

    cdreq_st_e             req_curSt;
    logic [3:0]            req_status;
    logic [2:0]            sdreq_op_in;

    logic                  sdreq_valid;
    logic                  sdreq_ready;
    logic [2:0]            sdreq_op;
    logic [ADDR_WIDTH-1:0] sdreq_addr;

    logic                  sursp_valid;
    logic [2:0]            sursp_rsp;
    // latched snoop response, read by the next-state decoder
    logic [2:0]            sursp_lat;

    logic                  blk_wr_en;

    logic                  cursp_valid;
    logic                  cursp_ready;
    logic [1:0]            cursp_rsp;

    modport master (
        input  cdreq_valid, cdreq_wr, cdreq_addr,
        input  lkup_hit, blk_curSt, snp_busy,
        input  sdreq_op_in, sdreq_ready,
        input  sursp_valid, sursp_rsp, cursp_ready,
        output cdreq_ready, lkup_en, lkup_addr,
        output req_curSt, req_status,
        output sdreq_valid, sdreq_op, sdreq_addr,
        output sursp_lat, blk_wr_en,
        output cursp_valid, cursp_rsp
    );

    modport slave (
        output cdreq_valid, cdreq_wr, cdreq_addr,
        output lkup_hit, blk_curSt, snp_busy,
        output sdreq_op_in, sdreq_ready,
        output sursp_valid, sursp_rsp, cursp_ready,
        input  cdreq_ready, lkup_en, lkup_addr,
        input  req_curSt, req_status,
        input  sdreq_valid, sdreq_op, sdreq_addr,
        input  sursp_lat, blk_wr_en,
        input  cursp_valid, cursp_rsp
    );

endinterface

// File: rtl/l1_sursp_timer.sv
// Snoop-response watchdog: clearable counter with terminal count.
// Saturates at TIMEOUT_CYC-1 so tc stays up until cleared.
module l1_sursp_timer
    import l1_cdreq_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] TC_VAL = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt_q;

    assign tc = (cnt_q == TC_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !tc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/l1_cdreq_seq.sv
// L1 CPU-down request sequencer: lookup, optional snoop, commit,
// then CPU response. One request in flight at a time.
module l1_cdreq_seq
    import l1_cdreq_seq_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic          clk,
    input logic          rst_n,
    l1_cdreq_seq_if.master bus
);

    cdreq_st_e             st_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_q;
    logic                  lkup_q;
    logic [3:0]            status_q;
    logic [2:0]            op_q;
    logic [2:0]            sursp_q;
    logic [1:0]            rsp_q;

    logic                  tmr_clr;
    logic                  tmr_en;
    logic                  tmr_tc;
    logic                  need_sdreq;
    logic                  sd_hs;

    assign bus.cdreq_ready = (st_q == CDREQ_IDLE) && !bus.snp_busy;
    assign bus.lkup_en     = lkup_q;
    assign bus.lkup_addr   = addr_q;
    assign bus.req_curSt   = st_q;
    assign bus.req_status  = status_q;
    assign bus.sdreq_valid = (st_q == CDREQ_SEND_SDREQ);
    assign bus.sdreq_op    = op_q;
    assign bus.sdreq_addr  = addr_q;
    assign bus.sursp_lat   = sursp_q;
    assign bus.blk_wr_en   = (st_q == CDREQ_UPDATE) && !bus.snp_busy;
    assign bus.cursp_valid = (st_q == CDREQ_SEND_RSP);
    assign bus.cursp_rsp   = rsp_q;

    // shared blocks need an invalidate before a write
    assign need_sdreq = !bus.lkup_hit ||
                        (wr_q && (bus.blk_curSt == MESI_S));

    assign sd_hs   = bus.sdreq_valid && bus.sdreq_ready;
    assign tmr_clr = sd_hs;
    assign tmr_en  = (st_q == CDREQ_WAIT_SURSP);

    l1_sursp_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .tc    (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= CDREQ_IDLE;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            lkup_q   <= 1'b0;
            status_q <= 4'b0000;
            op_q     <= SDREQ_RD;
            sursp_q  <= SURSP_NULL;
            rsp_q    <= CURSP_OKAY;
        end else begin
            lkup_q <= 1'b0;
            case (st_q)
                CDREQ_IDLE: begin
                    if (bus.cdreq_valid && bus.cdreq_ready) begin
                        addr_q <= bus.cdreq_addr;
                        wr_q   <= bus.cdreq_wr;
                        lkup_q <= 1'b1;
                        st_q   <= CDREQ_LOOKUP;
                    end
                end
                CDREQ_LOOKUP: begin
                    // lkup_hit is only meaningful the cycle after lkup_en
                    if (!lkup_q) begin
                        if (bus.snp_busy) begin
                            lkup_q <= 1'b1;
                        end else begin
                            status_q <= req_class(bus.lkup_hit, wr_q);
                            if (need_sdreq) begin
                                op_q <= bus.sdreq_op_in;
                                st_q <= CDREQ_SEND_SDREQ;
                            end else begin
                                st_q <= CDREQ_UPDATE;
                            end
                        end
                    end
                end
                CDREQ_SEND_SDREQ: begin
                    if (bus.sdreq_ready) begin
                        st_q <= CDREQ_WAIT_SURSP;
                    end
                end
                CDREQ_WAIT_SURSP: begin
                    if (bus.sursp_valid) begin
                        sursp_q <= bus.sursp_rsp;
                        st_q    <= CDREQ_UPDATE;
                    end else if (tmr_tc) begin
                        rsp_q <= CURSP_ERR;
                        st_q  <= CDREQ_SEND_RSP;
                    end
                end
                CDREQ_UPDATE: begin
                    if (!bus.snp_busy) begin
                        st_q <= CDREQ_SEND_RSP;
                    end
                end
                CDREQ_SEND_RSP: begin
                    if (bus.cursp_ready) begin
                        status_q <= 4'b0000;
                        rsp_q    <= CURSP_OKAY;
                        st_q     <= CDREQ_IDLE;
                    end
                end
                default: begin
                    st_q <= CDREQ_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_cdreq_seq.sv
// Directed bench for l1_cdreq_seq with hand-derived cycle timing.
// Inputs change 1ns after posedge; outputs are sampled there too.
module tb_l1_cdreq_seq;
    import l1_cdreq_seq_pkg::*;

    localparam int AW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_wr  = 0;
    int   n_sd  = 0;

    always #5 clk = ~clk;

    l1_cdreq_seq_if #(.ADDR_WIDTH(AW)) bus();

    l1_cdreq_seq #(
        .ADDR_WIDTH  (AW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) begin
        if (bus.blk_wr_en === 1'b1) n_wr++;
        if (bus.sdreq_valid === 1'b1) n_sd++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.cdreq_valid = 1'b0;
        bus.cdreq_wr    = 1'b0;
        bus.cdreq_addr  = '0;
        bus.lkup_hit    = 1'b0;
        bus.blk_curSt   = MESI_I;
        bus.snp_busy    = 1'b0;
        bus.sdreq_op_in = SDREQ_RD;
        bus.sdreq_ready = 1'b1;
        bus.sursp_valid = 1'b0;
        bus.sursp_rsp   = SURSP_NULL;
        bus.cursp_ready = 1'b1;
        #12;
        n_cmp++;
        if (bus.req_curSt !== CDREQ_IDLE) begin
            n_bad++;
            $display("FAIL rst_state got %0d want %0d", bus.req_curSt, CDREQ_IDLE);
        end
        n_cmp++;
        if ({bus.lkup_en, bus.sdreq_valid, bus.blk_wr_en, bus.cursp_valid} !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_strobes got %b want 0000",
                     {bus.lkup_en, bus.sdreq_valid, bus.blk_wr_en, bus.cursp_valid});
        end
        n_cmp++;
        if (bus.req_status !== 4'b0000 || bus.sdreq_op !== SDREQ_RD ||
            bus.cursp_rsp !== CURSP_OKAY || bus.lkup_addr !== '0) begin
            n_bad++;
            $display("FAIL rst_regs got st=%b op=%0d rsp=%0d addr=%h want 0/%0d/%0d/0",
                     bus.req_status, bus.sdreq_op, bus.cursp_rsp, bus.lkup_addr,
                     SDREQ_RD, CURSP_OKAY);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus.cdreq_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_ready got %b want 1", bus.cdreq_ready);
        end
    endtask

    task automatic test_read_hit(input logic [AW-1:0] a);
        int w0;
        int s0;
        w0 = n_wr;
        s0 = n_sd;
        bus.cursp_ready = 1'b1;
        bus.cdreq_wr    = 1'b0;
        bus.cdreq_addr  = a;
        bus.lkup_hit    = 1'b1;
        bus.blk_curSt   = MESI_E;
        bus.cdreq_valid = 1'b1;
        #1;
        n_cmp++;
        if (bus.cdreq_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rh_ready got %b want 1", bus.cdreq_ready);
        end
        tick();
        bus.cdreq_valid = 1'b0;
        n_cmp++;
        if (bus.lkup_en !== 1'b1 || bus.lkup_addr !== a ||
            bus.req_curSt !== CDREQ_LOOKUP) begin
            n_bad++;
            $display("FAIL rh_lookup got en=%b addr=%h st=%0d want 1/%h/%0d",
                     bus.lkup_en, bus.lkup_addr, bus.req_curSt, a, CDREQ_LOOKUP);
        end
        tick();
        n_cmp++;
        if (bus.lkup_en !== 1'b0) begin
            n_bad++;
            $display("FAIL rh_lkup_pulse got %b want 0", bus.lkup_en);
        end
        tick();
        n_cmp++;
        if (bus.req_status !== 4'b0001 || bus.req_curSt !== CDREQ_UPDATE ||
            bus.blk_wr_en !== 1'b1) begin
            n_bad++;
            $display("FAIL rh_update got st=%b cur=%0d wr=%b want 0001/%0d/1",
                     bus.req_status, bus.req_curSt, bus.blk_wr_en, CDREQ_UPDATE);
        end
        tick();
        n_cmp++;
        if (bus.cursp_valid !== 1'b1 || bus.cursp_rsp !== CURSP_OKAY ||
            bus.blk_wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL rh_rsp got v=%b rsp=%0d wr=%b want 1/%0d/0",
                     bus.cursp_valid, bus.cursp_rsp, bus.blk_wr_en, CURSP_OKAY);
        end
        tick();
        n_cmp++;
        if (bus.req_curSt !== CDREQ_IDLE || bus.req_status !== 4'b0000 ||
            (n_wr - w0) != 1 || (n_sd - s0) != 0) begin
            n_bad++;
            $display("FAIL rh_done got cur=%0d st=%b wr=%0d sd=%0d want %0d/0000/1/0",
                     bus.req_curSt, bus.req_status, n_wr - w0, n_sd - s0, CDREQ_IDLE);
        end
    endtask

    task automatic test_write_hit_shared();
        logic [AW-1:0] a;
        int w0;
        a  = 32'hA5A5_0100;
        w0 = n_wr;
        bus.cdreq_wr    = 1'b1;
        bus.cdreq_addr  = a;
        bus.lkup_hit    = 1'b1;
        bus.blk_curSt   = MESI_S;
        bus.sdreq_op_in = SDREQ_INV;
        bus.sdreq_ready = 1'b0;
        bus.cdreq_valid = 1'b1;
        tick();
        bus.cdreq_valid = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (bus.req_status !== 4'b0010 || bus.sdreq_valid !== 1'b1 ||
            bus.sdreq_op !== SDREQ_INV || bus.sdreq_addr !== a) begin
            n_bad++;
            $display("FAIL wh_sdreq got st=%b v=%b op=%0d addr=%h want 0010/1/%0d/%h",
                     bus.req_status, bus.sdreq_valid, bus.sdreq_op, bus.sdreq_addr,
                     SDREQ_INV, a);
        end
        bus.sdreq_op_in = SDREQ_RD;
        bus.cdreq_addr  = 32'h0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (bus.sdreq_valid !== 1'b1 || bus.sdreq_op !== SDREQ_INV ||
                bus.sdreq_addr !== a) begin
                n_bad++;
                $display("FAIL wh_stall%0d got v=%b op=%0d addr=%h want 1/%0d/%h",
                         i, bus.sdreq_valid, bus.sdreq_op, bus.sdreq_addr, SDREQ_INV, a);
            end
        end
        bus.sdreq_ready = 1'b1;
        tick();
        n_cmp++;
        if (bus.req_curSt !== CDREQ_WAIT_SURSP || bus.sdreq_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL wh_wait got cur=%0d v=%b want %0d/0",
                     bus.req_curSt, bus.sdreq_valid, CDREQ_WAIT_SURSP);
        end
        tick();
        tick();
        tick();
        n_cmp++;
        if (bus.req_curSt !== CDREQ_WAIT_SURSP || bus.blk_wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL wh_waiting got cur=%0d wr=%b want %0d/0",
                     bus.req_curSt, bus.blk_wr_en, CDREQ_WAIT_SURSP);
        end
        bus.sursp_valid = 1'b1;
        bus.sursp_rsp   = SURSP_SNOOP;
        tick();
        bus.sursp_valid = 1'b0;
        bus.sursp_rsp   = SURSP_NULL;
        n_cmp++;
        if (bus.blk_wr_en !== 1'b1 || bus.sursp_lat !== SURSP_SNOOP) begin
            n_bad++;
            $display("FAIL wh_commit got wr=%b lat=%0d want 1/%0d",
                     bus.blk_wr_en, bus.sursp_lat, SURSP_SNOOP);
        end
        tick();
        n_cmp++;
        if (bus.cursp_valid !== 1'b1 || bus.cursp_rsp !== CURSP_OKAY) begin
            n_bad++;
            $display("FAIL wh_rsp got v=%b rsp=%0d want 1/%0d",
                     bus.cursp_valid, bus.cursp_rsp, CURSP_OKAY);
        end
        tick();
        n_cmp++;
        if (bus.req_curSt !== CDREQ_IDLE || (n_wr - w0) != 1) begin
            n_bad++;
            $display("FAIL wh_done got cur=%0d wr=%0d want %0d/1",
                     bus.req_curSt, n_wr - w0, CDREQ_IDLE);
        end
    endtask

    task automatic test_read_miss();
        bus.cdreq_wr    = 1'b0;
        bus.cdreq_addr  = 32'h0000_2FC0;
        bus.lkup_hit    = 1'b0;
        bus.blk_curSt   = MESI_I;
        bus.sdreq_op_in = SDREQ_RD;
        bus.sdreq_ready = 1'b1;
        bus.cursp_ready = 1'b0;
        bus.cdreq_valid = 1'b1;
        tick();
        bus.cdreq_valid = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (bus.req_status !== 4'b0100 || bus.sdreq_op !== SDREQ_RD ||
            bus.sdreq_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rm_sdreq got st=%b op=%0d v=%b want 0100/%0d/1",
                     bus.req_status, bus.sdreq_op, bus.sdreq_valid, SDREQ_RD);
        end
        tick();
        bus.sursp_valid = 1'b1;
        bus.sursp_rsp   = SURSP_FETCH;
        tick();
        bus.sursp_valid = 1'b0;
        n_cmp++;
        if (bus.req_curSt !== CDREQ_UPDATE || bus.sursp_lat !== SURSP_FETCH) begin
            n_bad++;
            $display("FAIL rm_update got cur=%0d lat=%0d want %0d/%0d",
                     bus.req_curSt, bus.sursp_lat, CDREQ_UPDATE, SURSP_FETCH);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (bus.req_curSt !== CDREQ_SEND_RSP || bus.cursp_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL rm_hold%0d got cur=%0d v=%b want %0d/1",
                         i, bus.req_curSt, bus.cursp_valid, CDREQ_SEND_RSP);
            end
            if (i < 2) tick();
        end
        bus.cursp_ready = 1'b1;
        tick();
        n_cmp++;
        if (bus.cursp_valid !== 1'b0 || bus.req_curSt !== CDREQ_IDLE) begin
            n_bad++;
            $display("FAIL rm_done got v=%b cur=%0d want 0/%0d",
                     bus.cursp_valid, bus.req_curSt, CDREQ_IDLE);
        end
    endtask

    task automatic test_write_miss_timeout();
        int w0;
        bus.cdreq_wr    = 1'b1;
        bus.cdreq_addr  = 32'hDEAD_BEE0;
        bus.lkup_hit    = 1'b0;
        bus.sdreq_op_in = SDREQ_RDX;
        bus.sdreq_ready = 1'b1;
        bus.cursp_ready = 1'b1;
        bus.cdreq_valid = 1'b1;
        tick();
        bus.cdreq_valid = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (bus.req_status !== 4'b1000 || bus.sdreq_op !== SDREQ_RDX) begin
            n_bad++;
            $display("FAIL wm_sdreq got st=%b op=%0d want 1000/%0d",
                     bus.req_status, bus.sdreq_op, SDREQ_RDX);
        end
        tick();
        w0 = n_wr;
        for (int i = 1; i < TO; i++) begin
            tick();
            n_cmp++;
            if (bus.req_curSt !== CDREQ_WAIT_SURSP) begin
                n_bad++;
                $display("FAIL wm_wait%0d got cur=%0d want %0d",
                         i, bus.req_curSt, CDREQ_WAIT_SURSP);
            end
        end
        tick();
        n_cmp++;
        if (bus.req_curSt !== CDREQ_SEND_RSP || bus.cursp_valid !== 1'b1 ||
            bus.cursp_rsp !== CURSP_ERR) begin
            n_bad++;
            $display("FAIL wm_err got cur=%0d v=%b rsp=%0d want %0d/1/%0d",
                     bus.req_curSt, bus.cursp_valid, bus.cursp_rsp,
                     CDREQ_SEND_RSP, CURSP_ERR);
        end
        tick();
        n_cmp++;
        if (bus.cursp_rsp !== CURSP_OKAY || bus.req_status !== 4'b0000 ||
            (n_wr - w0) != 0) begin
            n_bad++;
            $display("FAIL wm_done got rsp=%0d st=%b wr=%0d want %0d/0000/0",
                     bus.cursp_rsp, bus.req_status, n_wr - w0, CURSP_OKAY);
        end
    endtask

    task automatic test_snp_busy();
        int w0;
        bus.cdreq_wr    = 1'b0;
        bus.cdreq_addr  = 32'h0000_0080;
        bus.lkup_hit    = 1'b1;
        bus.blk_curSt   = MESI_E;
        bus.cursp_ready = 1'b1;
        bus.snp_busy    = 1'b1;
        bus.cdreq_valid = 1'b1;
        #1;
        n_cmp++;
        if (bus.cdreq_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL sb_ready got %b want 0", bus.cdreq_ready);
        end
        tick();
        n_cmp++;
        if (bus.req_curSt !== CDREQ_IDLE) begin
            n_bad++;
            $display("FAIL sb_idle got %0d want %0d", bus.req_curSt, CDREQ_IDLE);
        end
        bus.snp_busy = 1'b0;
        tick();
        bus.cdreq_valid = 1'b0;
        tick();
        bus.snp_busy = 1'b1;
        tick();
        n_cmp++;
        if (bus.lkup_en !== 1'b1 || bus.req_curSt !== CDREQ_LOOKUP) begin
            n_bad++;
            $display("FAIL sb_relookup got en=%b cur=%0d want 1/%0d",
                     bus.lkup_en, bus.req_curSt, CDREQ_LOOKUP);
        end
        bus.snp_busy = 1'b0;
        tick();
        tick();
        w0 = n_wr;
        bus.snp_busy = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_curSt !== CDREQ_UPDATE || bus.blk_wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL sb_defer got cur=%0d wr=%b want %0d/0",
                     bus.req_curSt, bus.blk_wr_en, CDREQ_UPDATE);
        end
        tick();
        tick();
        n_cmp++;
        if (bus.req_curSt !== CDREQ_UPDATE || bus.blk_wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL sb_hold got cur=%0d wr=%b want %0d/0",
                     bus.req_curSt, bus.blk_wr_en, CDREQ_UPDATE);
        end
        bus.snp_busy = 1'b0;
        #1;
        n_cmp++;
        if (bus.blk_wr_en !== 1'b1) begin
            n_bad++;
            $display("FAIL sb_release got %b want 1", bus.blk_wr_en);
        end
        tick();
        n_cmp++;
        if (bus.cursp_valid !== 1'b1 || (n_wr - w0) != 1) begin
            n_bad++;
            $display("FAIL sb_rsp got v=%b wr=%0d want 1/1",
                     bus.cursp_valid, n_wr - w0);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.cdreq_wr    = 1'b1;
        bus.cdreq_addr  = 32'h1234_5678;
        bus.lkup_hit    = 1'b0;
        bus.sdreq_op_in = SDREQ_RDX;
        bus.sdreq_ready = 1'b1;
        bus.cdreq_valid = 1'b1;
        tick();
        bus.cdreq_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.req_curSt !== CDREQ_IDLE || bus.sdreq_op !== SDREQ_RD ||
            bus.lkup_addr !== '0 || bus.req_status !== 4'b0000 ||
            bus.cursp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mr_reset got cur=%0d op=%0d addr=%h st=%b v=%b want %0d/%0d/0/0000/0",
                     bus.req_curSt, bus.sdreq_op, bus.lkup_addr, bus.req_status,
                     bus.cursp_valid, CDREQ_IDLE, SDREQ_RD);
        end
        #3;
        rst_n = 1'b1;
        bus.sursp_valid = 1'b1;
        bus.sursp_rsp   = SURSP_FETCH;
        tick();
        tick();
        n_cmp++;
        if (bus.req_curSt !== CDREQ_IDLE || bus.cursp_valid !== 1'b0 ||
            bus.blk_wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL mr_ignore got cur=%0d v=%b wr=%b want %0d/0/0",
                     bus.req_curSt, bus.cursp_valid, bus.blk_wr_en, CDREQ_IDLE);
        end
        bus.sursp_valid = 1'b0;
        bus.sursp_rsp   = SURSP_NULL;
        test_read_hit(32'h0000_7700);
    endtask

    initial begin
        test_reset();
        test_read_hit(32'h1000_0040);
        test_write_hit_shared();
        test_read_miss();
        test_write_miss_timeout();
        test_snp_busy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
